// File: rtl/shifter_defs.sv
// Shared definitions for the 8-bit 3-stage barrel shifter and its clients.
//   MODE_*   : shifter mode encodings (LSL, LSR, ASR, ROR)
//   shift_by : one shifter stage, a fixed-distance shift in the selected mode
package shifter_defs;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_LSL = 2'b00;
    localparam logic [MODE_W-1:0] MODE_LSR = 2'b01;
    localparam logic [MODE_W-1:0] MODE_ASR = 2'b10;
    localparam logic [MODE_W-1:0] MODE_ROR = 2'b11;

    // Shift d by the constant distance sh (1..7) in the given mode.
    // ASR fills from bit 7 of this stage's input.
    function automatic logic [DATA_W-1:0] shift_by(input logic [DATA_W-1:0] d,
                                                   input logic [MODE_W-1:0] mode,
                                                   input int unsigned       sh);
        logic [DATA_W-1:0] r;
        case (mode)
            MODE_LSL: r = d << sh;
            MODE_LSR: r = d >> sh;
            MODE_ASR: r = DATA_W'($signed(d) >>> sh);
            default:  r = (d >> sh) | (d << (DATA_W - sh));
        endcase
        return r;
    endfunction

endpackage

// File: rtl/barrel_shifter_all.sv
// 8-bit 3-stage combinational barrel shifter, shift 0..7 per pass.
//   in   : operand
//   ctrl : shift amount (stage k shifts by 2^k when ctrl[k] is set)
//   mode : LSL / LSR / ASR / ROR
//   out  : shifted result
module barrel_shifter_all
    import shifter_defs::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [MODE_W-1:0] mode,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] s0;
    logic [DATA_W-1:0] s1;

    // Stages by 1, 2, 4; bit 7 survives every ASR stage so sign fill stays correct.
    always_comb begin
        s0  = ctrl[0] ? shift_by(in, mode, 1) : in;
        s1  = ctrl[1] ? shift_by(s0, mode, 2) : s0;
        out = ctrl[2] ? shift_by(s1, mode, 4) : s1;
    end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command front-end for barrel_shifter_all: accepts shifts wider than 3 bits and
// applies them as repeated passes (at most 7 per pass) through one shifter.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : command handshake (in_ready high only in IDLE)
//   in_data/in_amt/in_mode: operand, requested amount, shift mode
//   out_valid/out_ready   : result handshake
//   out_data/out_clamped  : result, amount-clamped-to-8 flag
//   busy                  : sequencer not in IDLE
module shift_cmd_sequencer
    import shifter_defs::*;
#(
    parameter int unsigned AMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_clamped,
    output logic              busy
);

    localparam int unsigned REM_W = 4;  // holds 0..8

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] data_r;
    logic [MODE_W-1:0] mode_r;
    logic [REM_W-1:0]  rem_r;
    logic              clamp_r;

    logic [REM_W-1:0]  eff_c;
    logic              clamp_c;
    logic [CTRL_W-1:0] step_c;
    logic [REM_W-1:0]  rem_next_c;
    logic [DATA_W-1:0] shifted_c;

    // Effective amount: rotates wrap mod 8, other modes saturate at 8.
    // Any bit above bit 2 set means in_amt >= 8; this is constant 0 when AMT_W == 3.
    always_comb begin
        eff_c   = REM_W'(in_amt[2:0]);
        clamp_c = 1'b0;
        if ((in_mode != MODE_ROR) && ((in_amt >> 3) != '0)) begin
            eff_c   = REM_W'(8);
            clamp_c = 1'b1;
        end
    end

    // Per-pass step is min(rem_r, 7).
    always_comb begin
        step_c     = (rem_r > REM_W'(7)) ? CTRL_W'(7) : rem_r[CTRL_W-1:0];
        rem_next_c = rem_r - REM_W'(step_c);
    end

    barrel_shifter_all u_shifter (
        .in   (data_r),
        .ctrl (step_c),
        .mode (mode_r),
        .out  (shifted_c)
    );

    assign in_ready = (state == ST_IDLE);

    // Sequencer FSM with registered outputs; out_data holds its value outside DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            data_r      <= '0;
            mode_r      <= MODE_LSL;
            rem_r       <= '0;
            clamp_r     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_clamped <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_r  <= in_data;
                        mode_r  <= in_mode;
                        rem_r   <= eff_c;
                        clamp_r <= clamp_c;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_r <= shifted_c;
                    rem_r  <= rem_next_c;
                    if (rem_next_c == '0) begin
                        out_valid   <= 1'b1;
                        out_data    <= shifted_c;
                        out_clamped <= clamp_r;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
